// File: rtl/timer_pkg.sv
// Shared encodings for the programmable delay timer: channel state and
// reload mode.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_channel_if.sv
// Control/status bundle between the timer top level and one timer channel.
interface timer_channel_if #(
  parameter int WIDTH = 27
);
  // No back-pressure: start/stop/periodic/period are sampled on every rising
  // edge (stop beats start). tick qualifies counting. timeout is a registered
  // one-cycle pulse; busy/count reflect the registered channel state.
  logic             tick;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] period;
  logic             timeout;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (
    output tick, start, stop, periodic, period,
    input  timeout, busy, count
  );

  modport slave (
    input  tick, start, stop, periodic, period,
    output timeout, busy, count
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN state, latched period and mode, tick counter
// and the registered Timeout pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic            clk,
  input  logic            rst_n,
  timer_channel_if.slave  bus
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;
  logic             terminal;

  assign terminal = (count_q == period_q - WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ONESHOT;
      period_q  <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Priority: stop, then start/retrigger, then counting. Both stop and start
  // take precedence over a coincident terminal tick, which suppresses it.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (bus.start) begin
      period_d = bus.period;
      mode_d   = bus.periodic ? MODE_PERIODIC : MODE_ONESHOT;
      count_d  = '0;
      if (bus.period == '0) begin
        state_d   = ST_IDLE;
        timeout_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN && bus.tick) begin
      if (terminal) begin
        count_d   = '0;
        timeout_d = 1'b1;
        if (mode_q == MODE_ONESHOT) state_d = ST_IDLE;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  assign bus.timeout = timeout_q;
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.count   = count_q;

endmodule

// File: rtl/programmable_delay_timer.sv
// Multi-channel programmable delay timer: one free-running prescaler feeding
// NUM_CH independent one-shot/periodic channels.
module programmable_delay_timer #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 27,
  parameter int PRESCALE = 1
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [NUM_CH-1:0]       Start,
  input  logic [NUM_CH-1:0]       Stop,
  input  logic [NUM_CH-1:0]       Periodic,
  input  logic [NUM_CH*WIDTH-1:0] Period,
  output logic [NUM_CH-1:0]       Timeout,
  output logic [NUM_CH-1:0]       Busy,
  output logic [NUM_CH*WIDTH-1:0] Count
);

  logic tick;

  // The prescaler phase is never disturbed by Start, so expiry jitters by up
  // to one prescale period depending on when Start lands.
  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] pre_q;

      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          pre_q <= '0;
        end else if (pre_q == PW'(PRESCALE - 1)) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end

      assign tick = (pre_q == PW'(PRESCALE - 1));
    end
  endgenerate

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel_if #(.WIDTH(WIDTH)) ch_if ();

    assign ch_if.tick     = tick;
    assign ch_if.start    = Start[i];
    assign ch_if.stop     = Stop[i];
    assign ch_if.periodic = Periodic[i];
    assign ch_if.period   = Period[i*WIDTH +: WIDTH];

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk   (Clock),
      .rst_n (Resetn),
      .bus   (ch_if)
    );

    assign Timeout[i]              = ch_if.timeout;
    assign Busy[i]                 = ch_if.busy;
    assign Count[i*WIDTH +: WIDTH] = ch_if.count;
  end

endmodule

// File: tb/tb_programmable_delay_timer.sv
// Bench for programmable_delay_timer: an episode-level model checks the
// PRESCALE=1 instance every cycle; directed literals pin specific scenarios.
module tb_programmable_delay_timer;

  localparam int NCH = 2;
  localparam int W   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A: PRESCALE = 1 ----------------
  logic [NCH-1:0]   start, stop, periodic;
  logic [NCH*W-1:0] period;
  logic [NCH-1:0]   timeout, busy;
  logic [NCH*W-1:0] count;

  programmable_delay_timer #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(1)) u_dut (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Stop(stop),
    .Periodic(periodic), .Period(period), .Timeout(timeout),
    .Busy(busy), .Count(count)
  );

  // ---------------- DUT B: PRESCALE = 4 ----------------
  logic [NCH-1:0]   start2, stop2, periodic2;
  logic [NCH*W-1:0] period2;
  logic [NCH-1:0]   timeout2, busy2;
  logic [NCH*W-1:0] count2;

  programmable_delay_timer #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(4)) u_dut_pre (
    .Clock(clk), .Resetn(rst_n), .Start(start2), .Stop(stop2),
    .Periodic(periodic2), .Period(period2), .Timeout(timeout2),
    .Busy(busy2), .Count(count2)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- episode model ----------------
  // Each channel remembers only its last live Start: the edge it was taken,
  // the period and the mode. Outputs follow from elapsed edges j = cyc - t0.
  int cyc;
  bit act_m [NCH];
  int t0_m  [NCH];
  int p_m   [NCH];
  bit per_m [NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < NCH; i++) act_m[i] <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < NCH; i++) begin
        if (stop[i]) begin
          act_m[i] <= 1'b0;
        end else if (start[i]) begin
          act_m[i] <= 1'b1;
          t0_m[i]  <= cyc + 1;
          p_m[i]   <= int'(period[i*W +: W]);
          per_m[i] <= periodic[i];
        end
      end
    end
  end

  function automatic void model_exp(input int i, output int e_to, output int e_busy,
                                    output int e_cnt);
    int j;
    e_to = 0; e_busy = 0; e_cnt = 0;
    j = cyc - t0_m[i];
    if (act_m[i]) begin
      if (p_m[i] == 0) begin
        e_to = (j == 0) ? 1 : 0;
      end else begin
        e_busy = (per_m[i] || j < p_m[i]) ? 1 : 0;
        e_cnt  = e_busy ? (j % p_m[i]) : 0;
        e_to   = (j > 0 && (j % p_m[i]) == 0 && (per_m[i] || j == p_m[i])) ? 1 : 0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cmd(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    start = st;
    stop  = sp;
    @(negedge clk);
    start = '0;
    stop  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- hand-computed tables ----------------
  int exp_cnt  [6] = '{1, 2, 3, 4, 0, 0};
  int exp_to   [6] = '{0, 0, 0, 0, 1, 0};
  int exp_busy [6] = '{1, 1, 1, 1, 0, 0};
  int pre_exp  [4] = '{7, 6, 5, 8};

  int pulses, last_k, n, got;
  int e_to, e_busy, e_cnt;

  initial begin
    rst_n = 1'b0;
    start = '0; stop = '0; periodic = '0; period = '0;
    start2 = '0; stop2 = '0; periodic2 = '0; period2 = '0;

    fork
      // compare process: DUT A against the model on every cycle
      forever begin
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
          model_exp(i, e_to, e_busy, e_cnt);
          chk($sformatf("cmp_timeout ch%0d cyc%0d", i, cyc), timeout[i], e_to);
          chk($sformatf("cmp_busy ch%0d cyc%0d", i, cyc), busy[i], e_busy);
          chk($sformatf("cmp_count ch%0d cyc%0d", i, cyc), count[i*W +: W], e_cnt);
        end
      end
      begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
      end
    join_none

    idle(3);
    chk("reset_busy", busy, 0);
    chk("reset_count", count, 0);
    chk("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    idle(2);

    // one-shot P=5 on ch0
    period[7:0] = 8'd5;
    periodic    = 2'b00;
    cmd(2'b01, 2'b00);
    chk("os_busy_start", busy[0], 1);
    chk("os_count_start", count[7:0], 0);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chk($sformatf("os_count_k%0d", k + 1), count[7:0], exp_cnt[k]);
      chk($sformatf("os_timeout_k%0d", k + 1), timeout[0], exp_to[k]);
      chk($sformatf("os_busy_k%0d", k + 1), busy[0], exp_busy[k]);
    end

    // periodic P=3 on ch1, stop at +7
    period[15:8] = 8'd3;
    periodic     = 2'b10;
    cmd(2'b10, 2'b00);
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      pulses += int'(timeout[1]);
    end
    chk("per_pulses_before_stop", pulses, 2);
    cmd(2'b00, 2'b10);
    chk("per_busy_after_stop", busy[1], 0);
    chk("per_count_after_stop", count[15:8], 0);
    pulses = int'(timeout[1]);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      pulses += int'(timeout[1]);
    end
    chk("per_pulses_after_stop", pulses, 0);

    // retrigger: P=4 at edge 0, P=6 at edge 3; later Period/mode changes ignored
    periodic    = 2'b00;
    period[7:0] = 8'd4;
    cmd(2'b01, 2'b00);
    idle(2);
    period[7:0] = 8'd6;
    cmd(2'b01, 2'b00);
    period[7:0] = 8'd2;
    periodic    = 2'b01;
    pulses = 0; last_k = -1;
    for (int k = 4; k <= 14; k++) begin
      idle(1);
      if (timeout[0]) begin
        pulses++;
        last_k = k;
      end
    end
    chk("retrig_pulses", pulses, 1);
    chk("retrig_edge", last_k, 9);
    periodic = 2'b00;

    // P=0
    period[7:0] = 8'd0;
    cmd(2'b01, 2'b00);
    chk("p0_timeout", timeout[0], 1);
    chk("p0_busy", busy[0], 0);
    chk("p0_count", count[7:0], 0);
    idle(1);
    chk("p0_timeout_after", timeout[0], 0);

    // Start and Stop together on ch1
    period[15:8] = 8'd3;
    cmd(2'b10, 2'b10);
    chk("startstop_busy", busy[1], 0);
    pulses = int'(timeout[1]);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      pulses += int'(timeout[1]);
    end
    chk("startstop_pulses", pulses, 0);

    // Stop on the terminal tick
    period[7:0] = 8'd3;
    cmd(2'b01, 2'b00);
    idle(2);
    cmd(2'b00, 2'b01);
    chk("term_stop_timeout", timeout[0], 0);
    chk("term_stop_busy", busy[0], 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      pulses += int'(timeout[0]);
    end
    chk("term_stop_pulses", pulses, 0);

    // simultaneous expiry: ch0 one-shot, ch1 periodic, both P=4
    period   = {8'd4, 8'd4};
    periodic = 2'b10;
    cmd(2'b11, 2'b00);
    idle(4);
    chk("simul_timeout", timeout, 2'b11);
    idle(4);
    chk("simul_timeout_second", timeout, 2'b10);
    cmd(2'b00, 2'b10);
    periodic = 2'b00;

    // asynchronous reset mid-count
    period[7:0] = 8'd10;
    cmd(2'b01, 2'b00);
    idle(3);
    chk("rst_count_before", count[7:0], 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_count", count, 0);
    chk("rst_async_timeout", timeout, 0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      pulses += int'(timeout[0]);
    end
    chk("rst_no_late_timeout", pulses, 0);
    period[7:0] = 8'd2;
    cmd(2'b01, 2'b00);
    idle(2);
    chk("rst_new_start_timeout", timeout[0], 1);

    // PRESCALE=4, P=2, one-shot: delay depends on the prescaler phase
    period2[7:0] = 8'd2;
    for (int it = 0; it < 5; it++) begin
      if (it > 0) idle(it - 1);
      start2 = 2'b01;
      @(negedge clk);
      start2 = 2'b00;
      chk($sformatf("pre_busy it%0d", it), busy2[0], 1);
      n = 0; got = 0;
      while (n < 20 && got == 0) begin
        @(negedge clk);
        n++;
        got = int'(timeout2[0]);
      end
      chk($sformatf("pre_seen it%0d", it), got, 1);
      chk($sformatf("pre_window it%0d", it), (n >= 5 && n <= 8) ? 1 : 0, 1);
      if (it > 0) chk($sformatf("pre_delay it%0d", it), n, pre_exp[it - 1]);
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
